// File: rtl/seq_shifter.sv
// Iterative one-bit-per-cycle shifter with valid/ready request and response.
// Left logical, right logical or right arithmetic; result held until taken.
module seq_shifter #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   shamt,
  input  logic             LR,
  input  logic             AL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   count;
  logic             lr_q;
  logic             al_q;
  logic             fill;
  logic [WIDTH-1:0] step;
  logic             accept;
  logic             last;

  assign accept = in_valid & in_ready;
  assign last   = (count == SHW'(1));

  // One-position move of the work register under the latched command.
  always_comb begin
    fill = al_q & work[WIDTH-1];
    step = work;
    if (lr_q)
      step = {work[WIDTH-2:0], 1'b0};
    else
      step = {fill, work[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      work      <= '0;
      count     <= '0;
      lr_q      <= 1'b0;
      al_q      <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            work     <= din;
            lr_q     <= LR;
            al_q     <= AL;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            if (shamt == '0) begin
              state     <= DONE;
              dout      <= din;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
              count <= shamt;
            end
          end
        end
        SHIFT: begin
          work  <= step;
          count <= count - 1'b1;
          if (last) begin
            state     <= DONE;
            dout      <= step;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and exhaustive-randomized checks of seq_shifter
// against an arithmetic shift model.
module tb_seq_shifter;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] shamt;
  logic       LR;
  logic       AL;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       busy;

  int total = 0;
  int bad   = 0;

  seq_shifter #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .shamt(shamt), .LR(LR), .AL(AL),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [7:0] d,
                                       input int sh,
                                       input logic lr, input logic al);
    int v;
    if (lr) return 8'((int'(d) * (1 << sh)) % 256);
    v = int'(d);
    if (al && d[7]) v = v - 256;
    if (v < 0) return 8'((v - ((1 << sh) - 1)) / (1 << sh));
    return 8'(v / (1 << sh));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and consume its response, checking everything.
  task automatic do_op(input logic [7:0] d, input int sh,
                       input logic lr, input logic al,
                       input int stall, input bit eager,
                       input bit verbose);
    int lat;
    int w;
    logic [7:0] exp;
    exp = model(d, sh, lr, al);
    w = 0;
    while (!in_ready && w < 30) begin
      tick();
      w++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    din = d;
    shamt = 3'(sh);
    LR = lr;
    AL = al;
    in_valid = 1'b1;
    out_ready = eager;
    tick();
    in_valid = 1'b0;
    din = 8'($urandom);
    shamt = 3'($urandom);
    LR = 1'($urandom);
    AL = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      if (verbose) chk("in_ready_low_busy", 32'(in_ready), 32'd0);
      tick();
      lat++;
    end
    chk("latency", 32'(lat), 32'((sh == 0) ? 1 : sh + 1));
    chk("dout", 32'(dout), 32'(exp));
    if (verbose) begin
      chk("busy_done", 32'(busy), 32'd1);
      chk("in_ready_done", 32'(in_ready), 32'd0);
    end
    if (!eager) begin
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'($urandom);
        din = 8'($urandom);
        tick();
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_dout", 32'(dout), 32'(exp));
        chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
    end else begin
      tick();
    end
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("dout_kept", 32'(dout), 32'(exp));
    if (verbose) chk("idle_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    logic [7:0] key;
    rst = 1'b1;
    in_valid = 1'b0;
    din = '0;
    shamt = '0;
    LR = 1'b0;
    AL = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);

    // Reset in the middle of SHIFT discards the operation.
    din = 8'h96; shamt = 3'd5; LR = 1'b0; AL = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("shift_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk("abort_no_valid", 32'(seen), 32'd0);

    do_op(8'h96, 3, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    chk("asr_0x96_3", 32'(dout), 32'hF2);
    do_op(8'h96, 3, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    chk("lsr_0x96_3", 32'(dout), 32'h12);
    do_op(8'h96, 3, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    chk("lsl_0x96_3", 32'(dout), 32'hB0);
    do_op(8'h81, 0, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    chk("zero_shift", 32'(dout), 32'h81);
    do_op(8'h80, 7, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    chk("asr_0x80_7", 32'(dout), 32'hFF);
    do_op(8'h80, 7, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    chk("lsr_0x80_7", 32'(dout), 32'h01);

    // Backpressure then an immediate back-to-back request.
    do_op(8'h5A, 2, 1'b1, 1'b0, 5, 1'b0, 1'b1);
    chk("bp_result", 32'(dout), 32'h68);
    do_op(8'hC3, 4, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    chk("b2b_result", 32'(dout), 32'hFC);

    // Reset colliding with an accept.
    din = 8'h77; shamt = 3'd2; LR = 1'b1; in_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_acc_busy", 32'(busy), 32'd0);
    chk("rst_acc_ready", 32'(in_ready), 32'd1);

    // Reset colliding with a response handshake.
    din = 8'h3C; shamt = 3'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_rsp_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    chk("rst_rsp_valid", 32'(out_valid), 32'd0);
    chk("rst_rsp_dout", 32'(dout), 32'h00);
    chk("rst_rsp_ready", 32'(in_ready), 32'd1);

    // Full din x shamt x mode sweep with randomized order and stalls.
    key = 8'($urandom);
    for (int m = 0; m < 3; m++) begin
      for (int sh = 0; sh < 8; sh++) begin
        for (int k = 0; k < 256; k++) begin
          int st;
          st = ($urandom_range(0, 15) == 0) ? $urandom_range(1, 3) : 0;
          do_op(8'(k) ^ key, sh, (m == 0), (m == 1), st,
                (st == 0) && ($urandom_range(0, 1) == 1), 1'b0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
